uart_echo_fifo: RTL and testbench

Buffers bytes received by the UART controller and feeds them back to the UART transmitter at a paced rate, so that back-to-back received bytes are never lost while a transmit frame is still in progress. It sits between the UART controller's receive outputs (data byte plus one-cycle ready pulse) and its transmit inputs (data byte plus one-cycle enable). It replaces direct one-cycle-delayed rx-to-tx echo wiring in the top level.

---
 rtl/uart_echo_fifo.sv | 121 ++++++++++++
 tb/tb_uart_echo_fifo.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/uart_echo_fifo.sv
// Byte FIFO between the UART receiver and transmitter. Received bytes are
// queued and replayed to the transmitter at a fixed pace of BYTE_GAP cycles.
module uart_echo_fifo #(
    parameter int DEPTH    = 16,
    parameter int ADDR_W   = 4,
    parameter int BYTE_GAP = 2400,
    parameter int GAP_W    = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        rx_dat,
    input  logic              rx_rdy,
    output logic [7:0]        tx_dat,
    output logic              tx_en,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    input  logic              clr_ovf,
    output logic              state_dbg
);

    // Handshake: rx_rdy is a one-cycle push strobe qualifying rx_dat (no
    // back-pressure, a push into a full FIFO is dropped); tx_en is a one-cycle
    // start strobe and tx_dat stays stable until the next tx_en.

    localparam int CW = ADDR_W + 1;
    localparam logic [CW-1:0]    COUNT_FULL = CW'(DEPTH);
    localparam logic [GAP_W-1:0] GAP_RELOAD = GAP_W'(BYTE_GAP - 1);

    typedef enum logic {
        IDLE = 1'b0,
        GAP  = 1'b1
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [7:0]        mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [GAP_W-1:0]  gap_cnt;
    logic [GAP_W-1:0]  gap_nxt;
    logic              full;
    logic              empty;
    logic              push;
    logic              drop;
    logic              issue;

    assign full      = (count == COUNT_FULL);
    assign empty     = (count == '0);
    assign push      = rx_rdy && !full;
    assign drop      = rx_rdy && full;
    assign state_dbg = state;

    always_comb begin
        state_nxt = state;
        gap_nxt   = gap_cnt;
        issue     = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    issue     = 1'b1;
                    gap_nxt   = GAP_RELOAD;
                    state_nxt = GAP;
                end
            end
            GAP: begin
                // Leaving on the edge that reaches zero keeps issues exactly BYTE_GAP apart.
                if (gap_cnt <= GAP_W'(1)) begin
                    gap_nxt   = '0;
                    state_nxt = IDLE;
                end else begin
                    gap_nxt = gap_cnt - GAP_W'(1);
                end
            end
            default: begin
                gap_nxt   = '0;
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            gap_cnt  <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            tx_en    <= 1'b0;
            tx_dat   <= 8'h00;
            overflow <= 1'b0;
        end else begin
            state   <= state_nxt;
            gap_cnt <= gap_nxt;
            tx_en   <= issue;
            if (push) begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
            end
            if (issue) begin
                tx_dat <= mem[rd_ptr];
                rd_ptr <= rd_ptr + ADDR_W'(1);
            end
            case ({push, issue})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (drop) begin
                overflow <= 1'b1;
            end else if (clr_ovf) begin
                overflow <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && push) begin
            mem[wr_ptr] <= rx_dat;
        end
    end

endmodule

// File: tb/tb_uart_echo_fifo.sv
// Bench for uart_echo_fifo: directed scenarios plus random traffic, every cycle
// compared against a queue-based model of the echo FIFO.
module tb_uart_echo_fifo;

  localparam int DEPTH    = 16;
  localparam int ADDR_W   = 4;
  localparam int BYTE_GAP = 40;
  localparam int GAP_W    = 6;

  logic              clk = 1'b0;
  logic              rst;
  logic [7:0]        rx_dat;
  logic              rx_rdy;
  logic [7:0]        tx_dat;
  logic              tx_en;
  logic [ADDR_W:0]   count;
  logic              overflow;
  logic              clr_ovf;
  logic              state_dbg;

  uart_echo_fifo #(
    .DEPTH(DEPTH),
    .ADDR_W(ADDR_W),
    .BYTE_GAP(BYTE_GAP),
    .GAP_W(GAP_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .rx_dat(rx_dat),
    .rx_rdy(rx_rdy),
    .tx_dat(tx_dat),
    .tx_en(tx_en),
    .count(count),
    .overflow(overflow),
    .clr_ovf(clr_ovf),
    .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // reference model: bytes waiting to be echoed, plus issue timing
  logic [7:0] exp_q[$];
  logic       m_ovf;
  logic       m_tx_en;
  logic [7:0] m_tx_dat;
  longint     edge_no;
  longint     last_issue;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, edge_no);
    end
  endtask

  task automatic model_edge(input logic r, input logic rdy, input logic [7:0] d, input logic clr);
    int n;
    bit iss;
    edge_no++;
    if (r) begin
      exp_q.delete();
      m_ovf      = 1'b0;
      m_tx_en    = 1'b0;
      m_tx_dat   = 8'h00;
      last_issue = edge_no - BYTE_GAP;
    end else begin
      n   = exp_q.size();
      iss = (n > 0) && ((edge_no - last_issue) >= BYTE_GAP);
      m_tx_en = iss;
      if (iss) begin
        m_tx_dat   = exp_q.pop_front();
        last_issue = edge_no;
      end
      if (rdy && n < DEPTH) exp_q.push_back(d);
      if (rdy && n >= DEPTH) m_ovf = 1'b1;
      else if (clr) m_ovf = 1'b0;
    end
  endtask

  // driver: one clock cycle of stimulus, then compare against the model
  task automatic cycle(input logic r, input logic rdy, input logic [7:0] d, input logic clr);
    @(negedge clk);
    rst = r; rx_rdy = rdy; rx_dat = d; clr_ovf = clr;
    @(posedge clk);
    model_edge(r, rdy, d, clr);
    #1;
    chk("tx_en", tx_en, m_tx_en);
    chk("tx_dat", tx_dat, m_tx_dat);
    chk("count", count, exp_q.size());
    chk("overflow", overflow, m_ovf);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic push(input logic [7:0] d);
    cycle(1'b0, 1'b1, d, 1'b0);
  endtask

  task automatic drain();
    for (int i = 0; i < (DEPTH + 2) * BYTE_GAP && exp_q.size() > 0; i++) idle(1);
    idle(BYTE_GAP);
  endtask

  initial begin
    rst = 1'b1; rx_rdy = 1'b0; rx_dat = 8'h00; clr_ovf = 1'b0;
    edge_no = 0; last_issue = 0;
    exp_q.delete(); m_ovf = 1'b0; m_tx_en = 1'b0; m_tx_dat = 8'h00;

    cycle(1'b1, 1'b0, 8'h00, 1'b0);
    cycle(1'b1, 1'b0, 8'h00, 1'b0);
    chk("reset_count", count, 0);
    chk("reset_tx_en", tx_en, 0);
    idle(7);

    // single byte: 2-cycle latency, one tx_en pulse
    push(8'hA5);
    chk("single_count1", count, 1);
    chk("single_no_tx", tx_en, 0);
    idle(1);
    chk("single_tx_en", tx_en, 1);
    chk("single_tx_dat", tx_dat, 8'hA5);
    chk("single_count0", count, 0);
    idle(1);
    chk("single_tx_low", tx_en, 0);
    drain();

    // burst of 5 paced bytes
    for (int i = 1; i <= 5; i++) push(8'(i));
    drain();
    chk("burst_ovf", overflow, 0);

    // overflow: 20 back-to-back pushes, then clear
    for (int i = 0; i < 20; i++) push(8'(i));
    chk("ovf_set", overflow, 1);
    drain();
    cycle(1'b0, 1'b0, 8'h00, 1'b1);
    chk("ovf_clr", overflow, 0);

    // pointer wrap: 3 rounds of 12
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 12; i++) push(8'(8'h40 + r * 12 + i));
      drain();
    end

    // push coinciding with issue while count is 1
    push(8'hC1);
    push(8'hC2);
    chk("same_edge_count", count, 1);
    chk("same_edge_tx", tx_dat, 8'hC1);
    drain();

    // reset with data queued, mid-gap
    for (int i = 0; i < 4; i++) push(8'(8'hD0 + i));
    idle(20);
    chk("pre_reset_count", count, 3);
    cycle(1'b1, 1'b0, 8'h00, 1'b0);
    chk("mid_reset_count", count, 0);
    chk("mid_reset_tx_en", tx_en, 0);
    idle(2);
    push(8'h5A);
    idle(1);
    chk("post_reset_tx_en", tx_en, 1);
    chk("post_reset_tx_dat", tx_dat, 8'h5A);
    drain();

    // random traffic with occasional clears and resets
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom_range(0, 999) < 3),
            ($urandom_range(0, 99) < 30),
            8'($urandom_range(0, 255)),
            ($urandom_range(0, 99) < 2));
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
